// File: rtl/canvas_painter.sv
// canvas_painter: 28x28 cell canvas painted by a mouse cursor, one stroke per frame tick.
// Optional soft brush (also touches the 4 neighbours) enabled by CANVAS_SOFT_BRUSH_EN.
module canvas_painter #(
  parameter logic [15:0] BRUSH_STEP = 16'h0200,
  parameter logic [15:0] MAX_VAL    = 16'h07FF
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_clk,
  input  logic [9:0]               BallX,
  input  logic [9:0]               BallY,
  input  logic                     paint,
  input  logic                     erase,
  input  logic                     clear,
  output logic [27:0][27:0][15:0]  canvas,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE,
    DIV,
    APPLY,
`ifdef CANVAS_SOFT_BRUSH_EN
    NEIGH,
`endif
    CLEAR
  } state_t;

  state_t      state;
  logic        frame_q;
  logic        clear_pending;
  logic        op_erase;
  logic [9:0]  rx;
  logic [9:0]  ry;
  logic [4:0]  col;
  logic [4:0]  row;
  logic [4:0]  clr_col;
  logic [4:0]  clr_row;
  logic        tick;
  logic        in_canvas;

  assign tick = frame_clk & ~frame_q;

  assign in_canvas = (BallX >= 10'd199) && (BallX <= 10'd590) &&
                     (BallY >= 10'd43)  && (BallY <= 10'd434);

  // 17-bit add/sub so the clamp sees the true result, never a wrapped one
  function automatic logic [15:0] upd(
    input logic [15:0] v,
    input logic [15:0] step,
    input logic        sub
  );
    logic [16:0] s;
    if (sub) begin
      s = {1'b0, v} - {1'b0, step};
      upd = s[16] ? 16'h0000 : s[15:0];
    end else begin
      s = {1'b0, v} + {1'b0, step};
      upd = (s > {1'b0, MAX_VAL}) ? MAX_VAL : s[15:0];
    end
  endfunction

`ifdef CANVAS_SOFT_BRUSH_EN
  localparam logic [15:0] HALF_STEP = BRUSH_STEP >> 1;

  logic [1:0] nidx;
  logic [5:0] n_col;
  logic [5:0] n_row;

  // 6-bit neighbour index: col-1 at col 0 wraps to 63 and is skipped
  always_comb begin
    n_col = {1'b0, col};
    n_row = {1'b0, row};
    unique case (nidx)
      2'd0:    n_col = {1'b0, col} - 6'd1;
      2'd1:    n_col = {1'b0, col} + 6'd1;
      2'd2:    n_row = {1'b0, row} - 6'd1;
      default: n_row = {1'b0, row} + 6'd1;
    endcase
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      canvas        <= '0;
      frame_q       <= 1'b0;
      clear_pending <= 1'b0;
      op_erase      <= 1'b0;
      rx            <= '0;
      ry            <= '0;
      col           <= '0;
      row           <= '0;
      clr_col       <= '0;
      clr_row       <= '0;
`ifdef CANVAS_SOFT_BRUSH_EN
      nidx          <= '0;
`endif
    end else begin
      frame_q <= frame_clk;
      if (clear)
        clear_pending <= 1'b1;
      unique case (state)
        IDLE: begin
          if (tick && clear_pending) begin
            state         <= CLEAR;
            busy          <= 1'b1;
            clear_pending <= clear;
            clr_col       <= '0;
            clr_row       <= '0;
          end else if (tick && (paint | erase) && in_canvas) begin
            state    <= DIV;
            busy     <= 1'b1;
            rx       <= BallX - 10'd199;
            ry       <= BallY - 10'd43;
            col      <= '0;
            row      <= '0;
            op_erase <= erase;
          end
        end
        DIV: begin
          if (rx >= 10'd14) begin
            rx  <= rx - 10'd14;
            col <= col + 5'd1;
          end
          if (ry >= 10'd14) begin
            ry  <= ry - 10'd14;
            row <= row + 5'd1;
          end
          if ((rx < 10'd14) && (ry < 10'd14))
            state <= APPLY;
        end
        APPLY: begin
          canvas[col][row] <= upd(canvas[col][row], BRUSH_STEP, op_erase);
`ifdef CANVAS_SOFT_BRUSH_EN
          state <= NEIGH;
          nidx  <= '0;
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
`ifdef CANVAS_SOFT_BRUSH_EN
        NEIGH: begin
          if ((n_col < 6'd28) && (n_row < 6'd28))
            canvas[n_col[4:0]][n_row[4:0]] <=
              upd(canvas[n_col[4:0]][n_row[4:0]], HALF_STEP, op_erase);
          nidx <= nidx + 2'd1;
          if (nidx == 2'd3) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`endif
        CLEAR: begin
          canvas[clr_col][clr_row] <= '0;
          if (clr_row == 5'd27) begin
            clr_row <= '0;
            clr_col <= clr_col + 5'd1;
          end else begin
            clr_row <= clr_row + 5'd1;
          end
          if ((clr_col == 5'd27) && (clr_row == 5'd27)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_painter.sv
// tb_canvas_painter: directed self-checking bench for canvas_painter.
// Neighbour expectations follow CANVAS_SOFT_BRUSH_EN when it is defined.
module tb_canvas_painter;

`ifdef CANVAS_SOFT_BRUSH_EN
  localparam int          NB = 4;
  localparam logic [15:0] HS = 16'h0100;
`else
  localparam int          NB = 0;
  localparam logic [15:0] HS = 16'h0000;
`endif

  logic                    Clk = 1'b0;
  logic                    Reset_n = 1'b1;
  logic                    frame_clk = 1'b0;
  logic [9:0]              BallX = '0;
  logic [9:0]              BallY = '0;
  logic                    paint = 1'b0;
  logic                    erase = 1'b0;
  logic                    clear = 1'b0;
  logic [27:0][27:0][15:0] canvas;
  logic [27:0][27:0][15:0] exp_c;
  logic                    busy;

  int errs = 0;
  int checks = 0;

  canvas_painter dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .BallX     (BallX),
    .BallY     (BallY),
    .paint     (paint),
    .erase     (erase),
    .clear     (clear),
    .canvas    (canvas),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  function automatic int first_diff(
    input logic [27:0][27:0][15:0] a,
    input logic [27:0][27:0][15:0] b
  );
    first_diff = -1;
    for (int c = 27; c >= 0; c--)
      for (int r = 27; r >= 0; r--)
        if (a[c][r] !== b[c][r])
          first_diff = c * 28 + r;
  endfunction

  task automatic hard_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    frame_clk = 1'b0;
    paint = 1'b0;
    erase = 1'b0;
    clear = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic run_tick(
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       p,
    input  logic       e,
    output int         cyc
  );
    BallX = x;
    BallY = y;
    paint = p;
    erase = e;
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      @(negedge Clk);
    end
    paint = 1'b0;
    erase = 1'b0;
    checks++;
    if (cyc >= 2000) begin
      errs++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles, want 0", busy, cyc);
    end
  endtask

  task automatic cmp_canvas(input string name);
    int d;
    d = first_diff(canvas, exp_c);
    checks++;
    if (d >= 0) begin
      errs++;
      $display("FAIL %s: cell[%0d][%0d] got %h want %h",
               name, d / 28, d % 28, canvas[d / 28][d % 28], exp_c[d / 28][d % 28]);
    end
  endtask

  task automatic test_reset();
    int c;
    #1 Reset_n = 1'b0;
    #1;
    exp_c = '0;
    cmp_canvas("reset_init_canvas");
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_init_busy: got %b want 0", busy);
    end
    @(negedge Clk) Reset_n = 1'b1;
    run_tick(10'd199, 10'd43, 1'b1, 1'b0, c);
    checks++;
    if (canvas[0][0] !== 16'h0200) begin
      errs++;
      $display("FAIL reset_precond: cell[0][0] got %h want 0200", canvas[0][0]);
    end
    #2 Reset_n = 1'b0;
    #1;
    cmp_canvas("reset_async_canvas");
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_async_busy: got %b want 0", busy);
    end
    @(negedge Clk) Reset_n = 1'b1;
  endtask

  task automatic test_origin();
    int c;
    hard_reset();
    run_tick(10'd199, 10'd43, 1'b1, 1'b0, c);
    checks++;
    if (c !== 2 + NB) begin
      errs++;
      $display("FAIL origin_busy_cycles: got %0d want %0d", c, 2 + NB);
    end
    exp_c = '0;
    exp_c[0][0] = 16'h0200;
    exp_c[1][0] = HS;
    exp_c[0][1] = HS;
    cmp_canvas("origin_canvas");
  endtask

  task automatic test_corner();
    int c;
    hard_reset();
    run_tick(10'd590, 10'd434, 1'b1, 1'b0, c);
    checks++;
    if (c !== 29 + NB) begin
      errs++;
      $display("FAIL corner_busy_cycles: got %0d want %0d", c, 29 + NB);
    end
    exp_c = '0;
    exp_c[27][27] = 16'h0200;
    exp_c[26][27] = HS;
    exp_c[27][26] = HS;
    cmp_canvas("corner_canvas");
  endtask

  task automatic test_saturate();
    int c;
    logic [15:0] pc [4] = '{16'h0200, 16'h0400, 16'h0600, 16'h07FF};
    logic [15:0] ec [5] = '{16'h05FF, 16'h03FF, 16'h01FF, 16'h0000, 16'h0000};
    logic [15:0] pn [4];
    logic [15:0] en [5];
    pn = '{HS, HS * 2, HS * 3, HS * 4};
    en = '{HS * 3, HS * 2, HS, 16'h0000, 16'h0000};
    hard_reset();
    for (int k = 0; k < 4; k++) begin
      run_tick(10'd269, 10'd113, 1'b1, 1'b0, c);
      checks++;
      if (canvas[5][5] !== pc[k]) begin
        errs++;
        $display("FAIL sat_paint%0d: cell[5][5] got %h want %h", k, canvas[5][5], pc[k]);
      end
      checks++;
      if (canvas[4][5] !== pn[k]) begin
        errs++;
        $display("FAIL sat_paint_left%0d: cell[4][5] got %h want %h", k, canvas[4][5], pn[k]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      run_tick(10'd269, 10'd113, 1'b1, 1'b1, c);
      checks++;
      if (canvas[5][5] !== ec[k]) begin
        errs++;
        $display("FAIL sat_erase%0d: cell[5][5] got %h want %h", k, canvas[5][5], ec[k]);
      end
      checks++;
      if (canvas[4][5] !== en[k]) begin
        errs++;
        $display("FAIL sat_erase_left%0d: cell[4][5] got %h want %h", k, canvas[4][5], en[k]);
      end
    end
    exp_c = '0;
    cmp_canvas("sat_final_canvas");
  endtask

  task automatic test_clear_mid();
    int c;
    hard_reset();
    run_tick(10'd199, 10'd43, 1'b1, 1'b0, c);
    BallX = 10'd590;
    BallY = 10'd434;
    paint = 1'b1;
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    clear = 1'b1;
    @(negedge Clk);
    clear = 1'b0;
    frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    c = 0;
    while (busy && c < 2000) begin
      c++;
      @(negedge Clk);
    end
    paint = 1'b0;
    checks++;
    if (canvas[27][27] !== 16'h0200) begin
      errs++;
      $display("FAIL clr_stroke_done: cell[27][27] got %h want 0200", canvas[27][27]);
    end
    repeat (5) @(negedge Clk);
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL clr_wait_tick: busy got %b want 0", busy);
    end
    run_tick(10'd0, 10'd0, 1'b0, 1'b0, c);
    checks++;
    if (c !== 784) begin
      errs++;
      $display("FAIL clr_busy_cycles: got %0d want 784", c);
    end
    exp_c = '0;
    cmp_canvas("clr_canvas");
  endtask

  task automatic test_outside();
    int c;
    hard_reset();
    run_tick(10'd198, 10'd43, 1'b1, 1'b0, c);
    checks++;
    if (c !== 0) begin
      errs++;
      $display("FAIL out_x198: busy cycles got %0d want 0", c);
    end
    run_tick(10'd199, 10'd435, 1'b1, 1'b0, c);
    checks++;
    if (c !== 0) begin
      errs++;
      $display("FAIL out_y435: busy cycles got %0d want 0", c);
    end
    run_tick(10'd591, 10'd100, 1'b1, 1'b0, c);
    checks++;
    if (c !== 0) begin
      errs++;
      $display("FAIL out_x591: busy cycles got %0d want 0", c);
    end
    exp_c = '0;
    cmp_canvas("out_canvas");
  endtask

  task automatic test_abort();
    logic seen;
    hard_reset();
    BallX = 10'd590;
    BallY = 10'd434;
    paint = 1'b1;
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    repeat (8) @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_busy: got %b want 0", busy);
    end
    @(negedge Clk) Reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      if (busy)
        seen = 1'b1;
    end
    paint = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errs++;
      $display("FAIL abort_no_restart: busy seen %b want 0", seen);
    end
    exp_c = '0;
    cmp_canvas("abort_canvas");
  endtask

  initial begin
    test_reset();
    test_origin();
    test_corner();
    test_saturate();
    test_clear_mid();
    test_outside();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/canvas_painter.md
CANVAS_PAINTER -- requirements
Module: canvas_painter

Interface
REQ-001 SHALL have parameter BRUSH_STEP, default 16'h0200, meaning the intensity added to or removed from the centre cell per stroke.
REQ-002 SHALL have parameter MAX_VAL, default 16'h07FF, meaning the saturation ceiling of a cell value.
REQ-003 SHALL have port Clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port frame_clk, input, 1 bit: VGA vsync-rate strobe, synchronous to Clk.
REQ-006 SHALL have ports BallX and BallY, input, 10 bits each: cursor position in screen pixels.
REQ-007 SHALL have ports paint and erase, input, 1 bit each: mouse button levels.
REQ-008 SHALL have port clear, input, 1 bit: single-cycle clear request pulse.
REQ-009 SHALL have port canvas, output, 16 bits x [27:0][27:0]: cell array indexed [column][row], registered.
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-011 SHALL register frame_clk once and define a stroke tick as a rising edge (current 1, previous 0).
REQ-012 SHALL set clear_pending on any cycle clear=1, including while busy, and drop it on entering CLEAR.
REQ-013 SHALL use FSM states IDLE, DIV, APPLY, NEIGH, CLEAR.
REQ-014 IDLE: on a tick with clear_pending set -> CLEAR; with clear_pending clear, on a tick with (paint|erase) and cursor in-canvas -> DIV; otherwise stay in IDLE.
REQ-015 In-canvas SHALL mean 199<=BallX<=590 and 43<=BallY<=434; an out-of-canvas tick SHALL cause no state change and no cell write.
REQ-016 On entering DIV, SHALL latch rx=BallX-199, ry=BallY-43, col=0, row=0, and latch op = erase ? ERASE : PAINT; erase SHALL win when both buttons are held.
REQ-017 DIV: each cycle, if rx>=14 then rx-=14 and col++; in parallel, if ry>=14 then ry-=14 and row++; when both are <14 -> APPLY; DIV SHALL last max(col,row)+1 cycles, at most 28.
REQ-018 APPLY: canvas[col][row] += BRUSH_STEP, saturating at MAX_VAL (PAINT), or -= BRUSH_STEP, floored at 0 (ERASE); duration 1 cycle.
REQ-019 NEIGH: 4 cycles visiting the neighbours in the order left, right, up, down, one per cycle, each updated by BRUSH_STEP>>1 with the same saturate/floor rules; a neighbour with index <0 or >27 SHALL be skipped but still consume its cycle; then -> IDLE.
REQ-020 CLEAR: SHALL write 0 to one cell per cycle in column-major order ([0][0],[0][1]..[27][27]) for 784 cycles, then -> IDLE.
REQ-021 Arithmetic SHALL be done in 17 bits before clamping; no cell SHALL ever wrap.
REQ-022 A tick arriving while busy SHALL be dropped; a clear arriving while busy SHALL be held pending and serviced at the first tick after return to IDLE.
REQ-023 Cell outputs SHALL change only in APPLY, NEIGH or CLEAR, or on reset.

Reset
REQ-024 Reset_n=0 SHALL immediately force state=IDLE, all 784 cells=16'h0000, busy=0, clear_pending=0, and the frame_clk register=0.
REQ-025 Reset asserted mid-stroke or mid-clear SHALL abort the operation; after release the block SHALL wait for a new tick.

Configuration
REQ-026 With macro CANVAS_SOFT_BRUSH_EN defined, APPLY SHALL go to NEIGH (soft brush); without it, APPLY SHALL go directly to IDLE, the NEIGH state SHALL not exist, and only the centre cell changes.

Verification
REQ-027 Reset: assert Reset_n=0 with cells non-zero -> all cells 0 and busy=0 in the same cycle, with no clock edge required.
REQ-028 BallX=199, BallY=43, paint=1, one tick -> canvas[0][0]=16'h0200; with the soft brush, [1][0]=[0][1]=16'h0100 and busy low after 1+1+4 cycles.
REQ-029 BallX=590, BallY=434, paint, one tick -> canvas[27][27]=16'h0200; DIV lasts 28 cycles; with the soft brush only [26][27] and [27][26] change.
REQ-030 Four paint ticks on cell [5][5] -> 16'h07FF, not 16'h0800; then erase with paint also held, five ticks -> 16'h0000 with no underflow.
REQ-031 clear pulse mid-stroke -> stroke completes; next tick -> CLEAR with busy high for exactly 784 cycles, then all cells 0.
REQ-032 BallX=198, paint, tick -> busy stays 0 and no cell changes.
